// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: state codes, opcode/funct
// constants, ALU operation codes and datapath mux select encodings.
package mc_ctrl_pkg;

    // Sequencer states; the numeric codes are visible on the debug State port.
    typedef enum logic [5:0] {
        StIf  = 6'd0,
        StId  = 6'd1,
        StExr = 6'd2,
        StExi = 6'd3,
        StAdr = 6'd4,
        StLd  = 6'd5,
        StSt  = 6'd6,
        StWbr = 6'd7,
        StWbi = 6'd8,
        StWbl = 6'd9,
        StBr  = 6'd10,
        StJ   = 6'd11
    } state_e;

    // Supported opcodes (instruction[31:26]).
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    // Supported R-type funct codes (instruction[5:0]).
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    // ALU operation codes.
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    // ALU B-operand select.
    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    // PC source select.
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    // Loads and stores share the address-calculation state.
    function automatic logic is_mem_op(logic [5:0] op);
        return (op == OpLw) || (op == OpSw);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported codes.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_op,
    output logic       illegal
);

    // Unsupported funct leaves the ALU on add; the sequencer discards the result.
    always_comb begin
        alu_op  = AluAdd;
        illegal = 1'b0;
        case (func)
            FnAdd:   alu_op = AluAdd;
            FnSub:   alu_op = AluSub;
            FnAnd:   alu_op = AluAnd;
            FnOr:    alu_op = AluOr;
            FnSlt:   alu_op = AluSlt;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_dffe6.sv
// Enabled register with asynchronous active-low clear; the 6-bit cell that holds
// the sequencer state.
module mc_dffe6 #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear forces zero immediately; otherwise load d when enabled.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control sequencer. Walks fetch/decode/execute/memory/write-back,
// drives datapath enables and selects, and stalls on the memory-ready handshake.
// The state register is the only storage; all outputs decode from State plus
// MemReady/Zero where an output depends on them.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 6,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic [5:0]         Op,
    input  logic [5:0]         Func,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    logic [STATE_W-1:0] state_q;
    state_e             state_cur;
    state_e             state_d;
    logic [2:0]         fn_alu_op;
    logic               fn_illegal;
    logic               op_legal;
    logic               fetch_ready;

    mc_alu_dec u_alu_dec (
        .func    (Func),
        .alu_op  (fn_alu_op),
        .illegal (fn_illegal)
    );

    mc_dffe6 #(
        .WIDTH (STATE_W)
    ) u_state_reg (
        .clk  (Clk),
        .clrn (Clrn),
        .en   (1'b1),
        .d    (STATE_W'(state_d)),
        .q    (state_q)
    );

    assign state_cur = state_e'(state_q);
    assign State     = state_q;

    // Held in reset the fetch decode must see MemReady as low so nothing is loaded.
    assign fetch_ready = MemReady & Clrn;

    // Opcodes the decode state can dispatch.
    always_comb begin
        op_legal = 1'b0;
        case (Op)
            OpRtype, OpAddi, OpLw, OpSw, OpBeq, OpJ: op_legal = 1'b1;
            default:                                 op_legal = 1'b0;
        endcase
    end

    // Next-state selection; unused codes fall back to fetch.
    always_comb begin
        state_d = StIf;
        case (state_cur)
            StIf: state_d = MemReady ? StId : StIf;
            StId: begin
                case (Op)
                    OpRtype:    state_d = StExr;
                    OpAddi:     state_d = StExi;
                    OpLw, OpSw: state_d = StAdr;
                    OpBeq:      state_d = StBr;
                    OpJ:        state_d = StJ;
                    default:    state_d = StIf;
                endcase
            end
            StExr: state_d = fn_illegal ? StIf : StWbr;
            StExi: state_d = StWbi;
            StAdr: begin
                if (Op == OpLw) begin
                    state_d = StLd;
                end else if (Op == OpSw) begin
                    state_d = StSt;
                end else begin
                    state_d = StIf;
                end
            end
            StLd:  state_d = MemReady ? StWbl : StLd;
            StSt:  state_d = MemReady ? StIf : StSt;
            StWbr, StWbi, StWbl, StBr, StJ: state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    // Output decode; each state overrides only the controls it owns.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SrcBReg;
        PCSource = PcSrcAlu;
        ALUOp    = ALUOP_W'(AluAdd);
        Illegal  = 1'b0;
        case (state_cur)
            StIf: begin
                // PC+4 computed every fetch cycle, committed only when memory answers.
                MemRead = 1'b1;
                ALUSrcB = SrcBFour;
                IRWrite = fetch_ready;
                PCWrite = fetch_ready;
            end
            StId: begin
                // Precompute the branch target into ALUOut.
                ALUSrcB = SrcBImmSh2;
                Illegal = ~op_legal;
            end
            StExr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBReg;
                ALUOp   = ALUOP_W'(fn_alu_op);
                Illegal = fn_illegal;
            end
            StExi, StAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
            end
            StLd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StSt: begin
                // Held through stalls; the state leaves on the single completing cycle.
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StWbr: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            StWbi: begin
                RegWrite = 1'b1;
            end
            StWbl: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            StBr: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SrcBReg;
                ALUOp    = ALUOP_W'(AluSub);
                PCSource = PcSrcAluOut;
                PCWrite  = Zero;
            end
            StJ: begin
                PCSource = PcSrcJump;
                PCWrite  = 1'b1;
            end
            default: begin
                // Unused codes drive nothing and return to fetch.
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: a table of directed cycles, hand-written reset and stall
// sequences, then randomized instructions checked against an instruction-level model.
module tb_mc_ctrl_fsm;

    logic       Clk = 1'b0;
    logic       Clrn;
    logic [5:0] Op;
    logic [5:0] Func;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, RegDst, MemToReg;
    logic       ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [5:0] State;

    mc_ctrl_fsm dut (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .Op       (Op),
        .Func     (Func),
        .Zero     (Zero),
        .MemReady (MemReady),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IorD     (IorD),
        .RegDst   (RegDst),
        .MemToReg (MemToReg),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .PCSource (PCSource),
        .ALUOp    (ALUOp),
        .Illegal  (Illegal),
        .State    (State)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [5:0] st;
        logic       pcw, irw, rw, mr, mw, iord, rdst, m2r, srca;
        logic [1:0] srcb, pcs;
        logic [2:0] aop;
        logic       ill;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       ready;
        logic       zero;
        ctl_t       exp;
    } vec_t;

    localparam logic [5:0] R = 6'h00, ADDI = 6'h08, LW = 6'h23, SW = 6'h2b;
    localparam logic [5:0] BEQ = 6'h04, J = 6'h02;

    ctl_t       act;
    vec_t       vq[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] fn_tab[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    assign act = {State, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, RegDst,
                  MemToReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal};

    // Expected control word for each step of an instruction, straight from the step's role.
    function automatic ctl_t blank(logic [5:0] st);
        ctl_t c = '0;
        c.st = st;
        return c;
    endfunction
    function automatic ctl_t fetch(logic r);
        ctl_t c = blank(6'd0);
        c.mr = 1'b1; c.srcb = 2'b01; c.irw = r; c.pcw = r;
        return c;
    endfunction
    function automatic ctl_t decode(logic ill);
        ctl_t c = blank(6'd1);
        c.srcb = 2'b11; c.ill = ill;
        return c;
    endfunction
    function automatic ctl_t exec_r(logic [2:0] aop, logic ill);
        ctl_t c = blank(6'd2);
        c.srca = 1'b1; c.aop = aop; c.ill = ill;
        return c;
    endfunction
    function automatic ctl_t exec_i(logic [5:0] st);
        ctl_t c = blank(st);
        c.srca = 1'b1; c.srcb = 2'b10;
        return c;
    endfunction
    function automatic ctl_t mem_ld();
        ctl_t c = blank(6'd5);
        c.mr = 1'b1; c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctl_t mem_st();
        ctl_t c = blank(6'd6);
        c.mw = 1'b1; c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctl_t wb(logic [5:0] st, logic rdst, logic m2r);
        ctl_t c = blank(st);
        c.rw = 1'b1; c.rdst = rdst; c.m2r = m2r;
        return c;
    endfunction
    function automatic ctl_t br(logic z);
        ctl_t c = blank(6'd10);
        c.srca = 1'b1; c.aop = 3'b001; c.pcs = 2'b01; c.pcw = z;
        return c;
    endfunction
    function automatic ctl_t jmp();
        ctl_t c = blank(6'd11);
        c.pcs = 2'b10; c.pcw = 1'b1;
        return c;
    endfunction

    // {illegal, aluop} for an R-type funct; illegal leaves the ALU on add.
    function automatic logic [3:0] r_decode(logic [5:0] f);
        case (f)
            6'h20:   return 4'b0000;
            6'h22:   return 4'b0001;
            6'h24:   return 4'b0010;
            6'h25:   return 4'b0011;
            6'h2a:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] func, input logic ready,
                       input logic zero, input ctl_t e);
        vec_t v;
        v.op = op; v.func = func; v.ready = ready; v.zero = zero; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input ctl_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: actual=%h (state %0d) required=%h (state %0d)",
                     name, act, act.st, e, e.st);
        end
    endtask

    // Apply queued cycles starting #1 after a rising edge; sample on the falling edge.
    task automatic run_vq(input string name);
        foreach (vq[i]) begin
            Op = vq[i].op; Func = vq[i].func; MemReady = vq[i].ready; Zero = vq[i].zero;
            @(negedge Clk);
            check($sformatf("%s[%0d]", name, i), vq[i].exp);
            @(posedge Clk);
            #1;
        end
        vq.delete();
    endtask

    // Instruction-level model: expand one instruction into its per-cycle control words.
    task automatic build(input logic [5:0] op, input logic [5:0] func, input logic z,
                         input int fst, input int mst);
        logic [3:0] rd;
        for (int i = 0; i < fst; i++) add(op, func, 1'b0, rb(), fetch(1'b0));
        add(op, func, 1'b1, rb(), fetch(1'b1));
        case (op)
            R: begin
                rd = r_decode(func);
                add(op, func, rb(), rb(), decode(1'b0));
                add(op, func, rb(), rb(), exec_r(rd[2:0], rd[3]));
                if (!rd[3]) add(op, func, rb(), rb(), wb(6'd7, 1'b1, 1'b0));
            end
            ADDI: begin
                add(op, func, rb(), rb(), decode(1'b0));
                add(op, func, rb(), rb(), exec_i(6'd3));
                add(op, func, rb(), rb(), wb(6'd8, 1'b0, 1'b0));
            end
            LW: begin
                add(op, func, rb(), rb(), decode(1'b0));
                add(op, func, rb(), rb(), exec_i(6'd4));
                for (int i = 0; i < mst; i++) add(op, func, 1'b0, rb(), mem_ld());
                add(op, func, 1'b1, rb(), mem_ld());
                add(op, func, rb(), rb(), wb(6'd9, 1'b0, 1'b1));
            end
            SW: begin
                add(op, func, rb(), rb(), decode(1'b0));
                add(op, func, rb(), rb(), exec_i(6'd4));
                for (int i = 0; i < mst; i++) add(op, func, 1'b0, rb(), mem_st());
                add(op, func, 1'b1, rb(), mem_st());
            end
            BEQ: begin
                add(op, func, rb(), rb(), decode(1'b0));
                add(op, func, rb(), z, br(z));
            end
            J: begin
                add(op, func, rb(), rb(), decode(1'b0));
                add(op, func, rb(), rb(), jmp());
            end
            default: add(op, func, rb(), rb(), decode(1'b1));
        endcase
    endtask

    initial begin
        logic [5:0] op, func;
        int         pick;

        // Reset: fetch decode with MemReady masked even though it is driven high.
        Clrn = 1'b0; MemReady = 1'b1; Op = 6'h00; Func = 6'h00; Zero = 1'b0;
        #3;
        check("reset", fetch(1'b0));
        @(negedge Clk);
        MemReady = 1'b0;
        Clrn     = 1'b1;
        @(posedge Clk);
        #1;
        check("post_reset", fetch(1'b0));

        // Directed table: add, lw with 2 mem stalls, beq taken/not, illegal op/funct, etc.
        add(R, 6'h20, 1, 0, fetch(1));  add(R, 6'h20, 0, 0, decode(0));
        add(R, 6'h20, 1, 1, exec_r(3'b000, 0)); add(R, 6'h20, 0, 0, wb(6'd7, 1, 0));
        add(LW, 6'h00, 1, 0, fetch(1)); add(LW, 6'h00, 1, 0, decode(0));
        add(LW, 6'h00, 0, 0, exec_i(6'd4));
        add(LW, 6'h00, 0, 0, mem_ld()); add(LW, 6'h00, 0, 1, mem_ld());
        add(LW, 6'h00, 1, 0, mem_ld()); add(LW, 6'h00, 0, 0, wb(6'd9, 0, 1));
        add(BEQ, 6'h00, 1, 0, fetch(1)); add(BEQ, 6'h00, 0, 0, decode(0));
        add(BEQ, 6'h00, 0, 1, br(1));
        add(BEQ, 6'h00, 1, 1, fetch(1)); add(BEQ, 6'h00, 0, 1, decode(0));
        add(BEQ, 6'h00, 1, 0, br(0));
        add(6'h3f, 6'h00, 1, 0, fetch(1)); add(6'h3f, 6'h00, 1, 0, decode(1));
        add(R, 6'h07, 1, 0, fetch(1)); add(R, 6'h07, 0, 0, decode(0));
        add(R, 6'h07, 1, 0, exec_r(3'b000, 1));
        add(R, 6'h2a, 1, 0, fetch(1)); add(R, 6'h2a, 0, 0, decode(0));
        add(R, 6'h2a, 0, 0, exec_r(3'b100, 0)); add(R, 6'h2a, 1, 0, wb(6'd7, 1, 0));
        add(J, 6'h00, 1, 0, fetch(1)); add(J, 6'h00, 0, 0, decode(0));
        add(J, 6'h00, 0, 0, jmp());
        add(ADDI, 6'h00, 1, 0, fetch(1)); add(ADDI, 6'h00, 0, 0, decode(0));
        add(ADDI, 6'h00, 1, 1, exec_i(6'd3)); add(ADDI, 6'h00, 0, 0, wb(6'd8, 0, 0));
        add(SW, 6'h00, 1, 0, fetch(1)); add(SW, 6'h00, 0, 0, decode(0));
        add(SW, 6'h00, 0, 0, exec_i(6'd4));
        add(SW, 6'h00, 0, 0, mem_st()); add(SW, 6'h00, 1, 0, mem_st());
        add(R, 6'h00, 0, 0, fetch(0));
        run_vq("table");

        // Fetch stall: five waiting cycles, then a single load pulse.
        Op = R; Func = 6'h20;
        for (int i = 0; i < 5; i++) begin
            MemReady = 1'b0;
            @(negedge Clk);
            check($sformatf("fetch_stall[%0d]", i), fetch(1'b0));
            @(posedge Clk);
            #1;
        end
        MemReady = 1'b1;
        @(negedge Clk);
        check("fetch_go", fetch(1'b1));
        @(posedge Clk);
        #1;
        MemReady = 1'b1;
        @(negedge Clk);
        check("fetch_done", decode(1'b0));
        @(posedge Clk);
        #1;
        add(R, 6'h20, 0, 0, exec_r(3'b000, 0)); add(R, 6'h20, 0, 0, wb(6'd7, 1, 0));
        run_vq("stall_tail");

        // Store interrupted by reset while stalled in the memory state.
        add(SW, 6'h00, 1, 0, fetch(1)); add(SW, 6'h00, 0, 0, decode(0));
        add(SW, 6'h00, 0, 0, exec_i(6'd4)); add(SW, 6'h00, 0, 0, mem_st());
        run_vq("sw_pre");
        MemReady = 1'b1;
        #1;
        check("sw_before_rst", mem_st());
        Clrn = 1'b0;
        #1;
        check("sw_rst_async", fetch(1'b0));
        @(posedge Clk);
        #1;
        check("sw_rst_hold", fetch(1'b0));
        @(negedge Clk);
        Clrn = 1'b1;
        #1;
        check("sw_rst_release", fetch(1'b1));
        @(posedge Clk);
        #1;
        add(SW, 6'h00, 0, 0, decode(0)); add(SW, 6'h00, 0, 0, exec_i(6'd4));
        add(SW, 6'h00, 1, 0, mem_st());
        run_vq("sw_refetch");

        // Randomized instruction stream against the model.
        for (int n = 0; n < 250; n++) begin
            pick = $urandom_range(0, 7);
            func = 6'($urandom_range(0, 63));
            case (pick)
                0, 1: begin
                    op = R;
                    if ($urandom_range(0, 9) < 8) func = fn_tab[$urandom_range(0, 4)];
                end
                2:       op = ADDI;
                3:       op = LW;
                4:       op = SW;
                5:       op = BEQ;
                6:       op = J;
                default: op = 6'($urandom_range(0, 63));
            endcase
            build(op, func, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_vq("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle CPU control sequencer. It is the driving end of the 6-bit enabled/cleared state and control registers.
- Decodes Op/Func of the latched instruction.
- Steps through the fetch, decode, execute, memory and write-back states.
- Drives write enables and mux selects for the PC, IR, register file, ALU and data memory.
- Stalls on a memory-ready handshake.

Parameters:
- STATE_W, 6, width of state register (matches 6-bit enabled/cleared register cells)
- ALUOP_W, 3, width of ALU operation code

Ports:
- Clk  in  1  rising-edge clock
- Clrn  in  1  asynchronous active-low reset
- Op  in  6  instruction[31:26] from IR
- Func  in  6  instruction[5:0] from IR
- Zero  in  1  ALU zero flag (valid in BR state)
- MemReady  in  1  memory handshake; access completes on the cycle it is high
- PCWrite  out  1  PC load enable
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register file write enable
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  0=PC address, 1=ALUOut address
- RegDst  out  1  0=rt, 1=rd
- MemToReg  out  1  0=ALUOut, 1=MDR
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUOp  out  ALUOP_W  000 add, 001 sub, 010 and, 011 or, 100 slt
- Illegal  out  1  one-cycle pulse on an unsupported opcode/funct
- State  out  STATE_W  current state, for debug

Behaviour:
- Reset: Clrn low forces State=S_IF asynchronously. While in reset, every output takes its S_IF decode with MemReady treated as 0: MemRead=1, ALUSrcB=01, all write enables and Illegal 0, all other selects 0.
- State encoding (6-bit):
  - S_IF=0, S_ID=1, S_EXR=2, S_EXI=3, S_ADR=4, S_LD=5, S_ST=6, S_WBR=7, S_WBI=8, S_WBL=9, S_BR=10, S_J=11.
  - Unused codes behave as S_IF on the next edge.
- Outputs are combinational from State, plus MemReady/Zero where noted. The state register is the only storage.
- S_IF:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stays in S_IF while MemReady=0; goes to S_ID when it is 1.
- S_ID: ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by Op:
  - 000000 -> S_EXR
  - 001000 -> S_EXI
  - 100011 or 101011 -> S_ADR
  - 000100 -> S_BR
  - 000010 -> S_J
  - anything else -> Illegal=1, back to S_IF
- S_EXR: ALUSrcA=1, ALUSrcB=00. ALUOp from Func:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other Func: Illegal=1, next S_IF, no write-back.
  - Otherwise next S_WBR.
- S_EXI: ALUSrcA=1, ALUSrcB=10, add; next S_WBI.
- S_ADR: same selects as S_EXI; next S_LD when Op=100011, S_ST when Op=101011.
- S_LD: MemRead=1, IorD=1. Hold while MemReady=0; next S_WBL when MemReady=1.
- S_ST: MemWrite=1, IorD=1. Hold while MemReady=0; next S_IF when MemReady=1.
  - MemWrite stays asserted for every stall cycle. Memory must not commit more than once.
- S_WBR: RegWrite=1, RegDst=1, MemToReg=0; next S_IF.
- S_WBI: RegWrite=1, RegDst=0, MemToReg=0; next S_IF.
- S_WBL: RegWrite=1, RegDst=0, MemToReg=1; next S_IF.
- S_BR: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PCWrite=Zero; next S_IF.
- S_J: PCSource=10, PCWrite=1; next S_IF.
- Latency per instruction with MemReady tied high: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
- Each stall cycle adds one.
- Reset mid-instruction: any write in progress is abandoned immediately; the first edge after Clrn rises evaluates S_IF.
- RegWrite, MemWrite and PCWrite are never asserted in the same cycle.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode/funct constants
  - ALUOp codes
  - ALUSrcB and PCSource encodings
- Sub-module mc_alu_dec: combinational Func -> ALUOp/illegal decode, reused by the datapath test model.
- The state register instantiates the team's 6-bit enabled/cleared register with En=1 and Clrn tied to reset.

Test Plan:
- Reset then release with MemReady=1, Op=000000, Func=100000. Required state sequence: S_IF, S_ID, S_EXR, S_WBR, S_IF. RegWrite=1 and RegDst=1 only in cycle 4; Illegal never asserts.
- lw (Op=100011) with MemReady low for 2 cycles in S_LD. Required: S_LD held 3 cycles, MemRead=1 and IorD=1 throughout, RegWrite=1 and MemToReg=1 in the next cycle, 7 cycles total.
- beq (Op=000100) run twice, Zero=1 then Zero=0. Required: PCWrite=1 with PCSource=01 in S_BR only when Zero=1; return to S_IF both times.
- Op=111111 from S_ID. Required: Illegal=1 for exactly one cycle, next state S_IF, no write enables asserted. Repeat with Op=000000, Func=000111: same response from S_EXR.
- sw (Op=101011) with Clrn pulsed low mid-S_ST. Required: MemWrite drops in the same cycle as Clrn; State=0 while Clrn is low; a fresh fetch begins after release.
- Fetch stall: MemReady=0 for 5 cycles in S_IF. Required: IRWrite=0 and PCWrite=0 with State=0 throughout; both pulse high for exactly one cycle when MemReady=1.
